// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner.
// Holds the default parameter values, the key-code width computation and
// small bit-vector helpers used by the debounce/event logic. All helpers work
// on a 64-bit zero-extended vector (ROWS*COLS never exceeds 64).
package keypad_pkg;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_SCAN_DIV = 1000;
    localparam int DEF_DEBOUNCE = 4;

    // Width needed to index n items; never below 1 so a 1-item case still
    // yields a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Key-code width: $clog2(ROWS*COLS), clamped to at least one bit.
    function automatic int keypad_kw(input int n_keys);
        return idx_width(n_keys);
    endfunction

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [5:0] lowest_set(input logic [63:0] v);
        logic [5:0] idx;
        idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            idx = v[i] ? 6'(i) : idx;
        end
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic single_bit(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

    // True when two or more bits are set.
    function automatic logic at_least_two(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column sequencer for the keypad scanner.
// Divides clk so each column is driven for SCAN_DIV cycles, walking columns
// 0..COLS-1 and wrapping.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   col_o         - one-hot column drive (registered)
//   slot_o        - index of the column currently driven
//   slot_end_o    - high on the last cycle of each slot (row sample point)
//   frame_end_o   - high on the last cycle of slot COLS-1
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [COLS-1:0]             col_o,
    output logic [idx_width(COLS)-1:0]  slot_o,
    output logic                        slot_end_o,
    output logic                        frame_end_o
);

    localparam int SW = idx_width(COLS);
    localparam int DW = idx_width(SCAN_DIV);

    logic [DW-1:0]   div_q,  div_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [COLS-1:0] col_q,  col_d;
    logic            slot_last_s;

    // Next-state for divider, slot index and column drive.
    always_comb begin
        slot_last_s = (div_q == DW'(SCAN_DIV - 1));
        div_d       = div_q;
        slot_d      = slot_q;
        if (slot_last_s) begin
            div_d = {DW{1'b0}};
            if (slot_q == SW'(COLS - 1)) begin
                slot_d = {SW{1'b0}};
            end else begin
                slot_d = slot_q + SW'(1);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
        // Column drive is kept in step with the slot index so it comes
        // straight from a flop.
        col_d = COLS'(1'b1) << slot_d;
    end

    // Sequencer state; reset parks on column 0, cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= {DW{1'b0}};
            slot_q <= {SW{1'b0}};
            col_q  <= COLS'(1'b1);
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
            col_q  <= col_d;
        end
    end

    assign col_o       = col_q;
    assign slot_o      = slot_q;
    assign slot_end_o  = slot_last_s;
    assign frame_end_o = slot_last_s && (slot_q == SW'(COLS - 1));

endmodule

// File: rtl/keypad_scanner_n.sv
// Matrix keypad scanner with frame-based debounce and key events.
// Columns are driven one at a time; rows are sampled at the end of each slot
// into a raw frame. A frame that repeats for DEBOUNCE further frames is
// committed to key_map, and commits that change key_map raise events.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   row          - row sense inputs (already synchronised)
//   col          - one-hot column drive
//   key_map      - debounced key map, bit r*COLS+c
//   key_code     - lowest set index of key_map (held across release)
//   key_valid    - 1-cycle pulse when a commit yields exactly one new key
//   key_release  - 1-cycle pulse when a commit empties key_map
//   key_down     - level, key_map non-zero
//   multi        - level, two or more keys in key_map
module keypad_scanner_n
    import keypad_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ROWS-1:0]                     row,
    output logic [COLS-1:0]                     col,
    output logic [ROWS*COLS-1:0]                key_map,
    output logic [keypad_kw(ROWS*COLS)-1:0]     key_code,
    output logic                                key_valid,
    output logic                                key_release,
    output logic                                key_down,
    output logic                                multi
);

    localparam int NK = ROWS * COLS;
    localparam int KW = keypad_kw(NK);
    localparam int SW = idx_width(COLS);
    localparam int CW = idx_width(DEBOUNCE + 1);

    logic [SW-1:0] slot_s;
    logic          slot_end_s;
    logic          frame_end_s;

    logic [NK-1:0] raw_q,   raw_d;
    logic [NK-1:0] prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [NK-1:0] map_q,   map_d;
    logic [KW-1:0] code_q,  code_d;
    logic          valid_q, valid_d;
    logic          rel_q,   rel_d;
    logic          down_q,  down_d;
    logic          multi_q, multi_d;
    logic [NK-1:0] frame_s;
    logic [63:0]   frame_wide_s;
    logic          commit_s;

    keypad_col_scan #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_o       (col),
        .slot_o      (slot_s),
        .slot_end_o  (slot_end_s),
        .frame_end_o (frame_end_s)
    );

    // Frame assembly, debounce counting and commit/event decode.
    always_comb begin
        // frame_s already includes the sample taken this cycle, so on the
        // frame-end cycle it is the complete frame.
        frame_s = raw_q;
        if (slot_end_s) begin
            for (int r = 0; r < ROWS; r++) begin
                frame_s[r*COLS + int'(slot_s)] = row[r];
            end
        end else begin
            frame_s = raw_q;
        end
        frame_wide_s = 64'(frame_s);

        raw_d    = frame_s;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        if (frame_end_s) begin
            prev_d = frame_s;
            if (frame_s == prev_q) begin
                commit_s = (cnt_q == CW'(DEBOUNCE - 1));
                if (cnt_q != CW'(DEBOUNCE)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cnt_d = {CW{1'b0}};
            end
        end else begin
            prev_d = prev_q;
        end

        map_d   = map_q;
        code_d  = code_q;
        down_d  = down_q;
        multi_d = multi_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        // A commit identical to the current map is not an event.
        if (commit_s && (frame_s != map_q)) begin
            map_d   = frame_s;
            down_d  = (frame_s != {NK{1'b0}});
            multi_d = at_least_two(frame_wide_s);
            valid_d = single_bit(frame_wide_s);
            // frame_s differs from map_q here, so an empty frame means
            // map_q was non-empty.
            rel_d   = (frame_s == {NK{1'b0}});
            if (frame_s != {NK{1'b0}}) begin
                code_d = KW'(lowest_set(frame_wide_s));
            end else begin
                code_d = code_q;
            end
        end else begin
            map_d = map_q;
        end
    end

    // Frame/debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q   <= {NK{1'b0}};
            prev_q  <= {NK{1'b0}};
            cnt_q   <= {CW{1'b0}};
            map_q   <= {NK{1'b0}};
            code_q  <= {KW{1'b0}};
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
            down_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            map_q   <= map_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
            down_q  <= down_d;
            multi_q <= multi_d;
        end
    end

    assign key_map     = map_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign key_down    = down_q;
    assign multi       = multi_q;

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Self-checking bench for keypad_scanner_n (ROWS=4, COLS=4, SCAN_DIV=4,
// DEBOUNCE=2). A keypad model turns the pressed-key set into row levels from
// the column drive. The reference model treats a frame as committed once it
// has been seen on DEBOUNCE+1 consecutive frames (the empty map counts as
// the frame before the first one after reset).
module tb_keypad_scanner_n;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = COLS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_map;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_down;
    logic        multi;

    logic [15:0] keys;

    int n_checks = 0;
    int n_errors = 0;
    int valid_seen = 0;
    int rel_seen = 0;

    // Reference model state
    logic [15:0] run_val;
    int          run_len;
    logic [15:0] exp_map;
    logic [3:0]  exp_code;
    bit          exp_valid;
    bit          exp_rel;

    keypad_scanner_n #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key_map     (key_map),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_down    (key_down),
        .multi       (multi)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column to its row.
    always_comb begin
        row = 4'd0;
        for (int r = 0; r < ROWS; r++) begin
            row[r] = |(keys[r*COLS +: COLS] & col);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        run_val   = 16'd0;
        run_len   = 1;
        exp_map   = 16'd0;
        exp_code  = 4'd0;
        exp_valid = 1'b0;
        exp_rel   = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] f);
        if (f == run_val) begin
            run_len++;
        end else begin
            run_val = f;
            run_len = 1;
        end
        exp_valid = 1'b0;
        exp_rel   = 1'b0;
        if (run_len >= DEBOUNCE + 1 && f != exp_map) begin
            exp_valid = ($countones(f) == 1);
            exp_rel   = (f == 16'd0);
            exp_map   = f;
            if (f != 16'd0) begin
                for (int b = 15; b >= 0; b--) begin
                    if (f[b]) exp_code = 4'(b);
                end
            end
        end
    endtask

    // i is the cycle position within the frame (0 = first cycle after frame end).
    task automatic check_outputs(input int i);
        chk("col", 32'(col), 32'(1) << (i / SCAN_DIV));
        chk("key_map", 32'(key_map), 32'(exp_map));
        chk("key_code", 32'(key_code), 32'(exp_code));
        chk("key_down", 32'(key_down), 32'(exp_map != 16'd0));
        chk("multi", 32'(multi), 32'($countones(exp_map) >= 2));
        chk("key_valid", 32'(key_valid), 32'((i == 0) && exp_valid));
        chk("key_release", 32'(key_release), 32'((i == 0) && exp_rel));
        chk("valid_release_excl", 32'(key_valid & key_release), 32'(0));
        if (key_valid) valid_seen++;
        if (key_release) rel_seen++;
    endtask

    // Hold key set k for ncyc cycles starting at a frame boundary.
    task automatic do_frame(input logic [15:0] k, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check_outputs(i);
            if (i == 0) keys = k;
            @(posedge clk);
            @(negedge clk);
        end
        if (ncyc == FRAME) model_frame(k);
    endtask

    task automatic hold(input logic [15:0] k, input int frames);
        for (int n = 0; n < frames; n++) do_frame(k, FRAME);
    endtask

    initial begin
        int v0;
        int r0;
        logic [15:0] k;
        logic [15:0] cur;

        keys  = 16'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs(0);
        rst_n = 1'b1;

        hold(16'h0000, 2);

        // Key 1 (row 0, col 1): one press event, then one release event.
        v0 = valid_seen;
        r0 = rel_seen;
        hold(16'h0002, 6);
        chk("key1_valid_count", 32'(valid_seen - v0), 32'(1));
        hold(16'h0000, 5);
        chk("key1_release_count", 32'(rel_seen - r0), 32'(1));

        // Key 5 bounce for a single frame.
        v0 = valid_seen;
        hold(16'h0020, 1);
        hold(16'h0000, 4);
        chk("bounce_valid_count", 32'(valid_seen - v0), 32'(0));

        // Keys 0 and 15 together, then release key 15 only.
        v0 = valid_seen;
        hold(16'h8001, 5);
        chk("multi_no_valid", 32'(valid_seen - v0), 32'(0));
        hold(16'h0001, 5);
        chk("single_after_multi", 32'(valid_seen - v0), 32'(1));
        hold(16'h0000, 4);

        // Key 5 committed, key 10 pending, reset mid-frame.
        hold(16'h0020, 4);
        hold(16'h0400, 2);
        do_frame(16'h0400, 7);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(0);
        @(posedge clk);
        @(negedge clk);
        check_outputs(0);
        rst_n = 1'b1;
        v0 = valid_seen;
        hold(16'h0400, 3);
        chk("reset_no_early_valid", 32'(valid_seen - v0), 32'(0));
        hold(16'h0400, 2);
        chk("reset_valid_after_3", 32'(valid_seen - v0), 32'(1));
        hold(16'h0000, 4);

        // Randomized patterns, each held for 1..4 frames.
        cur = 16'd0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: k = cur;
                1: k = 16'd0;
                2: k = 16'd1 << $urandom_range(0, 15);
                3: k = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                default: k = 16'($urandom);
            endcase
            cur = k;
            hold(k, $urandom_range(1, 4));
        end
        hold(16'h0000, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_n.md
KEYPAD_SCANNER_N -- requirements
Module: keypad_scanner_n

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of row inputs, range 1..8.
REQ-002 SHALL have parameter COLS, default 4: number of column drive outputs, range 1..8.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clk cycles each column is driven, minimum 2.
REQ-004 SHALL have parameter DEBOUNCE, default 4: identical consecutive frames needed to commit a change, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port row, input, ROWS bits: keypad row sense, active-high, externally synchronised.
REQ-008 SHALL have port col, output, COLS bits: one-hot column drive.
REQ-009 SHALL have port key_map, output, ROWS*COLS bits: debounced pressed-key map, bit index = r*COLS + c.
REQ-010 SHALL have port key_code, output, KW=$clog2(ROWS*COLS) bits: index of the lowest set bit of key_map.
REQ-011 SHALL have port key_valid, output, 1 bit: one-cycle pulse on a single-key press.
REQ-012 SHALL have port key_release, output, 1 bit: one-cycle pulse when key_map becomes all-zero.
REQ-013 SHALL have port key_down, output, 1 bit: level, high while key_map is non-zero.
REQ-014 SHALL have port multi, output, 1 bit: level, high while key_map has two or more bits set.

Function
REQ-015 SHALL drive column c during slot c, with slot order 0,1,..COLS-1, wrapping; each slot lasts exactly SCAN_DIV cycles, so one frame is COLS*SCAN_DIV cycles.
REQ-016 SHALL sample row only on the last cycle of each slot and store it into raw-frame bits r*COLS+c for that column; earlier cycles in the slot are settling time and are ignored.
REQ-017 SHALL, on the frame-end cycle (last cycle of slot COLS-1), compare the raw frame with the previous raw frame.
REQ-018 On a differing frame, SHALL clear stable_cnt to 0.
REQ-019 On an equal frame, SHALL increment stable_cnt, saturating at DEBOUNCE.
REQ-020 SHALL commit raw frame to key_map on an equal frame with stable_cnt==DEBOUNCE-1; a change therefore commits DEBOUNCE+1 frames after it first appears.
REQ-021 SHALL update all outputs in the cycle after the frame-end cycle; there is no combinational path from row to any output.
REQ-022 SHALL pulse key_valid for one cycle when a commit changes key_map to exactly one bit set, from either zero or a different map; key_code is valid in the same cycle.
REQ-023 SHALL NOT pulse key_valid when the committed map has two or more bits set; multi=1 and key_code = lowest set index.
REQ-024 SHALL pulse key_release when a commit changes key_map from non-zero to zero; key_code holds its last value.
REQ-025 SHALL treat a commit equal to the current key_map as no event: no pulse on any output.
REQ-026 SHALL ensure key_valid and key_release are never high in the same cycle.
REQ-027 A bounce that reverts to the committed map within DEBOUNCE frames SHALL produce no output change.

Reset
REQ-028 While rst_n=0: col=1 (column 0), key_map=0, key_code=0, key_valid=0, key_release=0, key_down=0, multi=0; slot counter, divider, raw and previous frames, and stable_cnt all zero.
REQ-029 SHALL assert reset asynchronously, release it synchronously to clk, and restart from slot 0, cycle 0 on the first edge after release.
REQ-030 Reset mid-frame SHALL discard the partial frame and issue no pulse on release.

Structure
REQ-031 SHALL place the KW computation and the default parameter values in shared package keypad_pkg.
REQ-032 SHALL implement the divider and column sequencer as sub-module keypad_col_scan, which outputs col and a frame_end strobe; debounce and event logic stay in the top module.

Verification
REQ-033 Test parameters SHALL be ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2 (frame = 16 cycles).
REQ-034 Scenario: after reset, col sequence is 1,2,4,8, each for 4 cycles, then wraps to 1 -> period 16 cycles.
REQ-035 Scenario: hold row=0001 during col=0010 (key 1) -> exactly one key_valid with key_code=1, key_map=0x0002, 3 frames after first sampled; no repeat pulse while held.
REQ-036 Scenario: key 1 held, then released -> one key_release 3 frames after release, key_map=0, key_down=0.
REQ-037 Scenario: press key 5 for 1 frame only (bounce) -> no key_valid, key_map stays 0.
REQ-038 Scenario: hold keys 0 and 15 -> multi=1, key_map=0x8001, key_code=0, no key_valid; release key 15 -> key_valid with key_code=0.
REQ-039 Scenario: pull rst_n low mid-frame while key 10 is stable-pending -> all outputs 0, col=1; after release, key_valid comes 3 full frames later.
